// File: rtl/ncl_bridge_pkg.sv
// Shared types and helpers for the NCL multiplier bridge: FSM states,
// dual-rail pair encodings and per-bit encode/decode functions.
package ncl_bridge_pkg;

  typedef enum logic [1:0] {
    WAIT_NULL = 2'd0,
    IDLE      = 2'd1,
    DATA      = 2'd2,
    NULLING   = 2'd3
  } state_t;

  // Pair ordering is {rail1, rail0}.
  localparam logic [1:0] RAIL_NULL    = 2'b00;
  localparam logic [1:0] RAIL_D0      = 2'b01;
  localparam logic [1:0] RAIL_D1      = 2'b10;
  localparam logic [1:0] RAIL_ILLEGAL = 2'b11;

  function automatic logic [1:0] ncl_encode(input logic b);
    return b ? RAIL_D1 : RAIL_D0;
  endfunction

  // The binary value of a pair is carried on rail1; an illegal pair still
  // decodes to its rail1 level so the captured word reflects the raw rails.
  function automatic logic ncl_decode(input logic [1:0] pair);
    return pair[1];
  endfunction

endpackage

// File: rtl/ncl_sync_bit.sv
// Single-bit multi-flop synchroniser for asynchronous core-side signals.
module ncl_sync_bit #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic [STAGES-1:0] chain;

  // NOTE: sequential state is written only with <= so every flop samples the
  // pre-edge value of its neighbour; blocking here would collapse the chain.
  always_ff @(posedge clk) begin
    if (rst) chain <= '0;
    else     chain <= {chain[STAGES-2:0], d};
  end

  assign q = chain[STAGES-1];

endmodule

// File: rtl/ncl_mult_bridge.sv
// Clocked shell around an NCL dual-rail WIDTH x WIDTH multiplier core.
// Optional golden-product check is enabled with NCL_BRIDGE_CHECK_EN.
module ncl_mult_bridge
  import ncl_bridge_pkg::*;
#(
  parameter int WIDTH       = 3,
  parameter int SYNC_STAGES = 2,
  parameter int TIMEOUT     = 255
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [WIDTH-1:0]     in_a,
  input  logic [WIDTH-1:0]     in_b,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [2*WIDTH-1:0]   out_p,
  output logic                 out_err,
  output logic [WIDTH-1:0]     Ai_rail1,
  output logic [WIDTH-1:0]     Ai_rail0,
  output logic [WIDTH-1:0]     Bi_rail1,
  output logic [WIDTH-1:0]     Bi_rail0,
  output logic                 Ki,
  input  logic                 Ko,
  input  logic [2*WIDTH-1:0]   Po_rail1,
  input  logic [2*WIDTH-1:0]   Po_rail0
);

  localparam int PW = 2 * WIDTH;
  localparam int CW = $clog2(TIMEOUT + 1);

  state_t state, state_n;

  logic [WIDTH-1:0] a_q, b_q;
  logic [WIDTH-1:0] a_r1, a_r0, b_r1, b_r0;
  logic [PW-1:0]    prod_dec;
  logic [CW-1:0]    phase_cnt;
  logic             phase_end;

  logic all_data_raw, all_null_raw, illegal_raw;
  logic all_data_s, all_null_s, illegal_s, ko_s;
  logic accept, capture, timeout, null_done, mismatch;

  // Completion detection works on the raw, unsynchronised product rails.
  always_comb begin
    all_data_raw = 1'b1;
    all_null_raw = 1'b1;
    illegal_raw  = 1'b0;
    for (int i = 0; i < PW; i++) begin
      case ({Po_rail1[i], Po_rail0[i]})
        RAIL_NULL:    all_data_raw = 1'b0;
        RAIL_ILLEGAL: begin
          all_data_raw = 1'b0;
          all_null_raw = 1'b0;
          illegal_raw  = 1'b1;
        end
        default:      all_null_raw = 1'b0;
      endcase
    end
  end

  ncl_sync_bit #(.STAGES(SYNC_STAGES)) u_sync_data (
    .clk(clk), .rst(rst), .d(all_data_raw), .q(all_data_s));
  ncl_sync_bit #(.STAGES(SYNC_STAGES)) u_sync_null (
    .clk(clk), .rst(rst), .d(all_null_raw), .q(all_null_s));
  ncl_sync_bit #(.STAGES(SYNC_STAGES)) u_sync_ill (
    .clk(clk), .rst(rst), .d(illegal_raw), .q(illegal_s));
  ncl_sync_bit #(.STAGES(SYNC_STAGES)) u_sync_ko (
    .clk(clk), .rst(rst), .d(Ko), .q(ko_s));

  // Po rails are read only once synced completion says they are settled;
  // the core holds them until Ki falls.
  always_comb begin
    prod_dec = '0;
    for (int i = 0; i < PW; i++)
      prod_dec[i] = ncl_decode({Po_rail1[i], Po_rail0[i]});
  end

  always_comb begin
    a_r1 = '0;
    a_r0 = '0;
    b_r1 = '0;
    b_r0 = '0;
    for (int i = 0; i < WIDTH; i++) begin
      {a_r1[i], a_r0[i]} = ncl_encode(a_q[i]);
      {b_r1[i], b_r0[i]} = ncl_encode(b_q[i]);
    end
  end

`ifdef NCL_BRIDGE_CHECK_EN
  logic [PW-1:0] golden_q;

  always_ff @(posedge clk) begin
    if (rst)         golden_q <= '0;
    else if (accept) golden_q <= PW'(in_a) * PW'(in_b);
  end

  assign mismatch = (prod_dec != golden_q);
`else
  assign mismatch = 1'b0;
`endif

  assign phase_end = (phase_cnt == CW'(TIMEOUT - 1));

  always_ff @(posedge clk) begin
    if (rst) state <= WAIT_NULL;
    else     state <= state_n;
  end

  // NOTE: every signal written here gets a default first, so no path through
  // the case leaves one unassigned and no latch is inferred.
  always_comb begin
    state_n   = state;
    in_ready  = 1'b0;
    accept    = 1'b0;
    capture   = 1'b0;
    timeout   = 1'b0;
    null_done = 1'b0;
    case (state)
      WAIT_NULL: begin
        if (all_null_s && ko_s) state_n = IDLE;
      end
      IDLE: begin
        in_ready = !out_valid || out_ready;
        if (in_valid && in_ready) begin
          accept  = 1'b1;
          state_n = DATA;
        end
      end
      DATA: begin
        if ((all_data_s || illegal_s) && !ko_s) begin
          capture = 1'b1;
          state_n = NULLING;
        end else if (phase_end) begin
          timeout = 1'b1;
          state_n = WAIT_NULL;
        end
      end
      NULLING: begin
        if (all_null_s && ko_s) begin
          null_done = 1'b1;
          state_n   = IDLE;
        end else if (phase_end) begin
          timeout = 1'b1;
          state_n = WAIT_NULL;
        end
      end
      default: state_n = WAIT_NULL;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst || (state_n != state))
      phase_cnt <= '0;
    else if (!phase_end)
      phase_cnt <= phase_cnt + 1'b1;
  end

  // NOTE: the operand and result registers are reset alongside control so the
  // rails and out_p come up at a defined NULL/zero, not merely "don't care".
  always_ff @(posedge clk) begin
    if (rst) begin
      a_q       <= '0;
      b_q       <= '0;
      Ai_rail1  <= '0;
      Ai_rail0  <= '0;
      Bi_rail1  <= '0;
      Bi_rail0  <= '0;
      Ki        <= 1'b1;
      out_valid <= 1'b0;
      out_p     <= '0;
      out_err   <= 1'b0;
    end else begin
      if (accept) begin
        a_q <= in_a;
        b_q <= in_b;
      end

      // DATA goes out one edge after acceptance and drops on the leaving edge.
      if (state == DATA && state_n == DATA) begin
        Ai_rail1 <= a_r1;
        Ai_rail0 <= a_r0;
        Bi_rail1 <= b_r1;
        Bi_rail0 <= b_r0;
      end else begin
        Ai_rail1 <= '0;
        Ai_rail0 <= '0;
        Bi_rail1 <= '0;
        Bi_rail0 <= '0;
      end

      if (capture)                   Ki <= 1'b0;
      else if (null_done || timeout) Ki <= 1'b1;

      if (capture) begin
        out_valid <= 1'b1;
        out_p     <= prod_dec;
        out_err   <= illegal_s || mismatch;
      end else if (timeout) begin
        out_valid <= 1'b1;
        out_p     <= '0;
        out_err   <= 1'b1;
      end else if (out_valid && out_ready) begin
        out_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_ncl_mult_bridge.sv
// Self-checking bench for ncl_mult_bridge with a behavioural NCL core model.
module tb_ncl_mult_bridge;

  localparam int W  = 3;
  localparam int PW = 2 * W;

  typedef enum int {M_NORMAL, M_ILLEGAL, M_STALL, M_PLUS1} mode_t;

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic            in_valid = 1'b0;
  logic            out_ready = 1'b0;
  logic [W-1:0]    in_a = '0;
  logic [W-1:0]    in_b = '0;
  logic            in_ready, out_valid, out_err, Ki;
  logic [PW-1:0]   out_p;
  logic [W-1:0]    Ai_rail1, Ai_rail0, Bi_rail1, Bi_rail0;
  logic            Ko;
  logic [PW-1:0]   Po_rail1, Po_rail0;

  mode_t mode = M_NORMAL;
  int    checks = 0;
  int    errors = 0;
  int unsigned exp_q[$];

  always #5 clk = ~clk;

  ncl_mult_bridge #(.WIDTH(W), .SYNC_STAGES(2), .TIMEOUT(16)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_a(in_a), .in_b(in_b),
    .out_valid(out_valid), .out_ready(out_ready), .out_p(out_p), .out_err(out_err),
    .Ai_rail1(Ai_rail1), .Ai_rail0(Ai_rail0), .Bi_rail1(Bi_rail1), .Bi_rail0(Bi_rail0),
    .Ki(Ki), .Ko(Ko), .Po_rail1(Po_rail1), .Po_rail0(Po_rail0)
  );

  wire in_is_data = (&(Ai_rail1 ^ Ai_rail0)) && (&(Bi_rail1 ^ Bi_rail0));
  wire in_is_null = ~|{Ai_rail1, Ai_rail0, Bi_rail1, Bi_rail0};
  wire rails_zero = in_is_null;

  // Behavioural core: multiplies whatever DATA wavefront arrives after a
  // random delay, then returns to NULL once inputs are NULL and Ki requests it.
  initial begin : core_model
    logic [PW-1:0] prod;
    Ko = 1'b1;
    Po_rail1 = '0;
    Po_rail0 = '0;
    forever begin
      wait (in_is_data);
      if (mode == M_STALL) begin
        wait (in_is_null);
      end else begin
        #($urandom_range(40, 5));
        prod = PW'(Ai_rail1) * PW'(Bi_rail1);
        if (mode == M_PLUS1) prod = prod + 1'b1;
        Po_rail1 = prod;
        Po_rail0 = ~prod;
        if (mode == M_ILLEGAL) begin
          Po_rail1[0] = 1'b1;
          Po_rail0[0] = 1'b1;
        end
        Ko = 1'b0;
        wait (!Ki && in_is_null);
        #($urandom_range(40, 5));
        Po_rail1 = '0;
        Po_rail0 = '0;
        Ko = 1'b1;
        wait (Ki);
      end
    end
  end

  initial begin : watchdog
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic send(input int unsigned a, input int unsigned b);
    int n;
    n = 0;
    @(negedge clk);
    in_valid = 1'b1;
    in_a = W'(a);
    in_b = W'(b);
    while (!in_ready && n < 500) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (!in_ready) begin
      errors++;
      $display("FAIL send_wait: in_ready=%b, required 1 within 500 cycles", in_ready);
      in_valid = 1'b0;
    end else begin
      if (!rails_zero || Ki !== 1'b1) begin
        errors++;
        $display("FAIL pre_null: rails_zero=%b Ki=%b, required rails_zero=1 Ki=1",
                 rails_zero, Ki);
      end
      @(posedge clk);
      #1 in_valid = 1'b0;
    end
  endtask

  task automatic receive(input int unsigned exp_p, input logic exp_err, input string name);
    int n;
    n = 0;
    @(negedge clk);
    out_ready = 1'b1;
    while (!out_valid && n < 500) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (out_valid !== 1'b1 || out_p !== PW'(exp_p) || out_err !== exp_err) begin
      errors++;
      $display("FAIL %s: valid=%b p=%0d err=%b, required valid=1 p=%0d err=%b",
               name, out_valid, out_p, out_err, exp_p, exp_err);
    end
    @(posedge clk);
    #1 out_ready = 1'b0;
  endtask

  task automatic test_reset();
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if (!rails_zero || Ki !== 1'b1 || in_ready !== 1'b0 || out_valid !== 1'b0 ||
        out_p !== '0 || out_err !== 1'b0) begin
      errors++;
      $display("FAIL reset_values: rails_zero=%b Ki=%b in_ready=%b out_valid=%b out_p=%0d out_err=%b, required 1 1 0 0 0 0",
               rails_zero, Ki, in_ready, out_valid, out_p, out_err);
    end
    @(negedge clk);
    rst = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    checks++;
    if (in_ready !== 1'b0) begin
      errors++;
      $display("FAIL reset_ready_early: in_ready=%b, required 0 before sync settles", in_ready);
    end
  endtask

  task automatic test_basic();
    send(0, 0);
    receive(0, 1'b0, "mul_0x0");
    send(7, 7);
    receive(49, 1'b0, "mul_7x7");
  endtask

  task automatic test_back_to_back();
    int n;
    exp_q.push_back(5 * 6);
    exp_q.push_back(3 * 2);
    send(5, 6);
    @(negedge clk);
    in_valid = 1'b1;
    in_a = 3'd3;
    in_b = 3'd2;
    n = 0;
    while (!out_valid && n < 100) begin
      @(negedge clk);
      n++;
    end
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      checks++;
      if (out_valid !== 1'b1 || out_p !== PW'(exp_q[0]) || in_ready !== 1'b0) begin
        errors++;
        $display("FAIL b2b_hold[%0d]: valid=%b p=%0d in_ready=%b, required 1 %0d 0",
                 i, out_valid, out_p, in_ready, exp_q[0]);
      end
    end
    // Pop the first result and accept the pending operands on the same edge.
    out_ready = 1'b1;
    #1;
    checks++;
    if (in_ready !== 1'b1 || out_p !== PW'(exp_q[0])) begin
      errors++;
      $display("FAIL b2b_pop_accept: in_ready=%b p=%0d, required 1 %0d",
               in_ready, out_p, exp_q[0]);
    end
    void'(exp_q.pop_front());
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    out_ready = 1'b0;
    checks++;
    if (out_valid !== 1'b0) begin
      errors++;
      $display("FAIL b2b_popped: out_valid=%b, required 0", out_valid);
    end
    receive(exp_q.pop_front(), 1'b0, "b2b_second");
  endtask

  task automatic test_illegal();
    int unsigned a, b;
    a = $urandom_range(7, 0);
    b = $urandom_range(7, 0);
    mode = M_ILLEGAL;
    send(a, b);
    receive((a * b) | 1, 1'b1, "illegal_pair");
    mode = M_NORMAL;
    a = $urandom_range(7, 1);
    b = $urandom_range(7, 1);
    send(a, b);
    receive(a * b, 1'b0, "after_illegal");
  endtask

  task automatic test_timeout();
    int n;
    mode = M_STALL;
    send($urandom_range(7, 1), $urandom_range(7, 1));
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!out_valid && n < 17);
    checks++;
    if (out_valid !== 1'b1) begin
      errors++;
      $display("FAIL timeout_valid: out_valid=%b after %0d cycles, required 1 within 17", out_valid, n);
    end
    checks++;
    if (out_p !== '0 || out_err !== 1'b1 || !rails_zero || Ki !== 1'b1) begin
      errors++;
      $display("FAIL timeout_result: p=%0d err=%b rails_zero=%b Ki=%b, required 0 1 1 1",
               out_p, out_err, rails_zero, Ki);
    end
    out_ready = 1'b1;
    @(posedge clk);
    #1 out_ready = 1'b0;
    mode = M_NORMAL;
    send(2, 3);
    receive(6, 1'b0, "timeout_recover");
  endtask

  task automatic test_reset_mid();
    int n;
    mode = M_STALL;
    send(1, 2);
    n = 0;
    while (rails_zero && n < 10) begin
      @(negedge clk);
      n++;
    end
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    checks++;
    if (!rails_zero || Ki !== 1'b1 || out_valid !== 1'b0 || in_ready !== 1'b0) begin
      errors++;
      $display("FAIL reset_mid: rails_zero=%b Ki=%b out_valid=%b in_ready=%b, required 1 1 0 0",
               rails_zero, Ki, out_valid, in_ready);
    end
    @(negedge clk);
    rst = 1'b0;
    mode = M_NORMAL;
    send(4, 4);
    receive(16, 1'b0, "after_reset_mid");
  endtask

  task automatic test_check();
    int unsigned a, b;
    logic exp_err;
`ifdef NCL_BRIDGE_CHECK_EN
    exp_err = 1'b1;
`else
    exp_err = 1'b0;
`endif
    a = $urandom_range(7, 0);
    b = $urandom_range(7, 0);
    mode = M_PLUS1;
    send(a, b);
    receive(a * b + 1, exp_err, "check_plus_one");
    mode = M_NORMAL;
  endtask

  task automatic test_random();
    int unsigned a, b;
    for (int i = 0; i < 20; i++) begin
      a = $urandom_range(7, 0);
      b = $urandom_range(7, 0);
      exp_q.push_back(a * b);
      send(a, b);
      repeat ($urandom_range(5, 0)) @(negedge clk);
      receive(exp_q.pop_front(), 1'b0, "random_mul");
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_back_to_back();
    test_illegal();
    test_timeout();
    test_reset_mid();
    test_check();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
